// File: rtl/i2c_led_regfile_pkg.sv
// Shared definitions for the I2C-fed LED colour register file: FSM encoding and defaults.
package i2c_led_regfile_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPtr,
        StData,
        StDiscard
    } state_e;

    localparam int unsigned NumLedsDefault     = 8;
    localparam int unsigned BytesPerLedDefault = 3;
    localparam logic [6:0]  I2cSlaveAddr       = 7'h42;

endpackage

// File: rtl/i2c_led_regfile.sv
// Byte sink behind the I2C slave: first byte after START sets the write pointer, the rest fill
// the LED colour memory with auto-increment. Registered read port and frame-update strobe.
module i2c_led_regfile
    import i2c_led_regfile_pkg::*;
#(
    parameter int unsigned NUM_LEDS      = NumLedsDefault,
    parameter int unsigned BYTES_PER_LED = BytesPerLedDefault,
    localparam int unsigned DEPTH        = NUM_LEDS * BYTES_PER_LED,
    localparam int unsigned ADDR_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        data,
    input  logic              data_valid_i,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              frame_update,
    output logic              busy
);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              dirty_q;
    logic              busy_q;
    logic              frame_update_q;
    logic [7:0]        rd_data_q;
    logic [7:0]        mem_q [0:DEPTH-1];

    logic rd_in_range;
    logic ptr_in_range;

    // Extra bit keeps the comparison correct when DEPTH is a power of two.
    assign rd_in_range  = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));
    assign ptr_in_range = (32'(data) < DEPTH);

    assign rd_data      = rd_data_q;
    assign frame_update = frame_update_q;
    assign busy         = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            ptr_q          <= '0;
            dirty_q        <= 1'b0;
            busy_q         <= 1'b0;
            frame_update_q <= 1'b0;
            rd_data_q      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            frame_update_q <= 1'b0;
            rd_data_q      <= rd_in_range ? mem_q[rd_addr] : 8'h00;

            if (stop) begin
                state_q        <= StIdle;
                busy_q         <= 1'b0;
                frame_update_q <= dirty_q;
                dirty_q        <= 1'b0;
            end else if (start) begin
                // A repeated START keeps pending writes so only the final STOP strobes.
                if (state_q == StIdle) begin
                    dirty_q <= 1'b0;
                end
                state_q <= StPtr;
                busy_q  <= 1'b1;
            end else if (data_valid_i) begin
                case (state_q)
                    StPtr: begin
                        if (ptr_in_range) begin
                            ptr_q   <= data[ADDR_W-1:0];
                            state_q <= StData;
                        end else begin
                            state_q <= StDiscard;
                        end
                    end
                    StData: begin
                        mem_q[ptr_q] <= data;
                        ptr_q        <= (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
                        dirty_q      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_led_regfile.sv
// Self-checking bench for i2c_led_regfile: directed scenarios plus random traffic against a
// transaction-level model of the colour memory.
module tb_i2c_led_regfile;

    localparam int Depth = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       data_valid_i;
    logic       start;
    logic       stop;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_update;
    logic       busy;

    i2c_led_regfile dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .data_valid_i (data_valid_i),
        .start        (start),
        .stop         (stop),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_update (frame_update),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: memory image, open-transaction flag, pending-write flag, pointer and phase.
    logic [7:0] m_mem [0:Depth-1];
    bit         m_open;
    bit         m_dirty;
    bit         m_have_ptr;
    bit         m_discard;
    int         m_ptr;

    int fu_count  = 0;
    int fu_double = 0;
    bit fu_prev   = 1'b0;

    always @(negedge clk) begin
        if (frame_update === 1'b1 && fu_prev) fu_double++;
        if (frame_update === 1'b1) fu_count++;
        fu_prev = (frame_update === 1'b1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < Depth; i++) m_mem[i] = 8'h00;
        m_open     = 0;
        m_dirty    = 0;
        m_have_ptr = 0;
        m_discard  = 0;
        m_ptr      = 0;
    endtask

    // One clock: drive inputs at negedge, predict, then check the registered outputs.
    task automatic step(input bit st, input bit sp, input bit dv, input logic [7:0] d,
                        input logic [4:0] ra);
        logic [7:0] exp_rd;
        bit         exp_fu;
        start        = st;
        stop         = sp;
        data_valid_i = dv;
        data         = d;
        rd_addr      = ra;
        exp_rd       = (int'(ra) < Depth) ? m_mem[ra] : 8'h00;
        exp_fu       = 0;
        if (sp) begin
            exp_fu  = m_dirty;
            m_open  = 0;
            m_dirty = 0;
        end else if (st) begin
            if (!m_open) m_dirty = 0;
            m_open     = 1;
            m_have_ptr = 0;
            m_discard  = 0;
        end else if (dv && m_open && !m_discard) begin
            if (!m_have_ptr) begin
                if (int'(d) < Depth) begin
                    m_ptr      = int'(d);
                    m_have_ptr = 1;
                end else begin
                    m_discard = 1;
                end
            end else begin
                m_mem[m_ptr] = d;
                m_ptr        = (m_ptr + 1) % Depth;
                m_dirty      = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        start        = 0;
        stop         = 0;
        data_valid_i = 0;
        check_eq("busy", 32'(busy), 32'(m_open));
        check_eq("frame_update", 32'(frame_update), 32'(exp_fu));
        check_eq("rd_data", 32'(rd_data), 32'(exp_rd));
    endtask

    function automatic logic [4:0] rnd_addr();
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic do_start();           step(1, 0, 0, 8'h00, rnd_addr()); endtask
    task automatic do_stop();            step(0, 1, 0, 8'h00, rnd_addr()); endtask
    task automatic do_byte(input logic [7:0] d); step(0, 0, 1, d, rnd_addr()); endtask

    // Independent constant check of one memory location through the read port.
    task automatic read_const(input string tag, input logic [4:0] a, input logic [7:0] exp);
        step(0, 0, 0, 8'h00, a);
        check_eq(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame_update", 32'(frame_update), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        int fu0;
        logic [7:0] t1 [0:8];
        t1 = '{8'hAB, 8'h36, 8'h84, 8'hD0, 8'h25, 8'h5A, 8'h00, 8'h77, 8'h0D};

        reset        = 1;
        start        = 0;
        stop         = 0;
        data_valid_i = 0;
        data         = 0;
        rd_addr      = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_frame_update", 32'(frame_update), 32'd0);
        check_eq("reset_rd_data", 32'(rd_data), 32'd0);
        reset = 0;

        // 1: nine-byte burst from pointer 0
        fu0 = fu_count;
        do_start();
        do_byte(8'h00);
        for (int i = 0; i < 9; i++) do_byte(t1[i]);
        do_stop();
        step(0, 0, 0, 8'h00, 5'd0);
        check_eq("t1_pulses", 32'(fu_count - fu0), 32'd1);
        for (int i = 0; i < 9; i++) read_const("t1_mem", 5'(i), t1[i]);

        // 2: wrap from the last byte back to 0
        fu0 = fu_count;
        do_start();
        do_byte(8'h16);
        do_byte(8'h11);
        do_byte(8'h22);
        do_byte(8'h33);
        do_byte(8'h44);
        do_stop();
        step(0, 0, 0, 8'h00, 5'd0);
        check_eq("t2_pulses", 32'(fu_count - fu0), 32'd1);
        read_const("t2_mem22", 5'd22, 8'h11);
        read_const("t2_mem23", 5'd23, 8'h22);
        read_const("t2_mem0", 5'd0, 8'h33);
        read_const("t2_mem1", 5'd1, 8'h44);

        // 3: out-of-range pointer, and an empty transaction
        fu0 = fu_count;
        do_start();
        do_byte(8'h18);
        do_byte(8'h55);
        do_stop();
        do_start();
        do_stop();
        step(0, 0, 0, 8'h00, 5'd0);
        check_eq("t3_pulses", 32'(fu_count - fu0), 32'd0);
        read_const("t3_mem0", 5'd0, 8'h33);
        read_const("t3_mem24", 5'd24, 8'h00);

        // 4: data_valid coincident with stop is dropped
        fu0 = fu_count;
        do_start();
        do_byte(8'h02);
        do_byte(8'hEE);
        step(0, 1, 1, 8'h99, 5'd3);
        step(0, 0, 0, 8'h00, 5'd0);
        check_eq("t4_pulses", 32'(fu_count - fu0), 32'd1);
        read_const("t4_mem2", 5'd2, 8'hEE);
        read_const("t4_mem3", 5'd3, 8'hD0);

        // 5: repeated START, single strobe at final stop
        fu0 = fu_count;
        do_start();
        do_byte(8'h03);
        do_byte(8'hAA);
        do_start();
        check_eq("t5_busy_rs", 32'(busy), 32'd1);
        do_byte(8'h05);
        do_byte(8'hBB);
        do_stop();
        step(0, 0, 0, 8'h00, 5'd0);
        check_eq("t5_pulses", 32'(fu_count - fu0), 32'd1);
        read_const("t5_mem3", 5'd3, 8'hAA);
        read_const("t5_mem5", 5'd5, 8'hBB);

        // 6: reset mid-transaction clears everything, no strobe
        fu0 = fu_count;
        do_start();
        do_byte(8'h00);
        do_byte(8'h01);
        do_byte(8'h02);
        do_reset();
        step(0, 0, 0, 8'h00, 5'd0);
        check_eq("t6_pulses", 32'(fu_count - fu0), 32'd0);
        for (int i = 0; i < 32; i++) read_const("t6_mem", 5'(i), 8'h00);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            logic [7:0]  d;
            r = $urandom_range(0, 199);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 27));
            if (r == 0) do_reset();
            else step(r < 10, r >= 190, $urandom_range(0, 1) == 1, d, rnd_addr());
        end

        check_eq("no_double_pulse", 32'(fu_double), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
